tx_66b_framer: RTL and testbench
================================

# tx_66b_framer

Transmit-side sequencer for the 64b/66b link: accepts 64-bit payload words from upstream over a valid/ready handshake and drives the scrambler's data input, sync header and advance enable. It inserts idle control blocks when upstream has nothing to send, and honours the transceiver gearbox pause slot. It sits between the TX packet source and the scrambler; its `tx_sequence` output goes to the transceiver gearbox sequence input.

## Interface
- `DATA_WIDTH`, 64: payload word width; only 64 is supported.
- `SEQ_MAX`, 32: gearbox sequence terminal count; the counter runs 0..SEQ_MAX, and SEQ_MAX is the pause slot.
- `INIT_IDLES`, 16: number of idle blocks sent after link enable before upstream data is accepted.

- `clk`  in  1  TX user clock
- `rst`  in  1  reset; one clock; asynchronous, active-high
- `link_en`  in  1  link enable from link control
- `s_data`  in  64  payload word, bit 0 transmitted first
- `s_ctrl`  in  1  1 = control block (sync 2'b10), 0 = data block (sync 2'b01)
- `s_valid`  in  1  upstream word valid
- `s_ready`  out  1  word accepted when s_valid & s_ready
- `scr_data`  out  64  to scrambler data input
- `scr_sync`  out  2  to scrambler sync_info
- `scr_enable`  out  1  scrambler state advance
- `tx_sequence`  out  6  gearbox sequence count
- `init_done`  out  1  high in RUN state

## Operation
- FSM states:
  - DISABLED: outputs the idle block, scr_enable=0.
  - INIT: sends INIT_IDLES idle blocks, scr_enable=1 except in pause slots.
  - RUN: passes data through.
- FSM transitions:
  - DISABLED→INIT when link_en=1.
  - INIT→RUN after the INIT_IDLES-th enabled idle.
  - Any state→DISABLED on the cycle after link_en=0; the init count clears.
- Idle block: `scr_data`=64'h1E00_0000_0000_0000, `scr_sync`=2'b10. The constant is IDLE_BLOCK in the package.
- RUN, non-pause output cycle:
  - If a word was accepted the previous cycle: scr_data=s_data and scr_sync={s_ctrl,~s_ctrl}, with scr_enable=1.
  - Otherwise the idle block is sent, with scr_enable=1.
- Pause output cycle (tx_sequence==SEQ_MAX), in every state:
  - scr_enable=0.
  - scr_data and scr_sync hold their previous values.
  - No word is consumed.
- `s_ready` = (state==RUN) && (next tx_sequence != SEQ_MAX). It is decoded from registers only, with no combinational path from s_valid.
- Sequence counter:
  - Free-runs in all states after reset.
  - Increments every cycle and wraps from SEQ_MAX to 0.
  - Width is $clog2(SEQ_MAX+1); the output is zero-extended to 6 bits.

## Timing
- All outputs except s_ready are registered.
- Latency: a word accepted at edge t appears on scr_data/scr_sync with scr_enable=1 in cycle t+1.
- Reset values:
  - scr_data=IDLE_BLOCK, scr_sync=2'b10.
  - scr_enable=0, s_ready=0, init_done=0.
  - tx_sequence=0, state=DISABLED.
- Pause cadence: exactly one pause cycle per SEQ_MAX+1 cycles. s_ready is low in the cycle before each pause output cycle.
- link_en falling while a word is being accepted: that word is still output next cycle, then DISABLED follows.
- rst asserted mid-frame: immediate asynchronous return to reset values. The in-flight word is dropped.
- s_valid held with s_ready low: upstream holds data stable (AXI-style). No word is lost or duplicated across a pause.

## Configuration
- `TX_FRAMER_STATS_EN` defined adds three outputs:
  - `data_cnt` (32): words accepted.
  - `idle_cnt` (32): idles sent in RUN with scr_enable=1.
  - `pause_cnt` (32): pause cycles.
- The counters wrap at 2^32, reset to 0, and clear on entry to DISABLED.
- Without the macro the ports and counters do not exist and behaviour is otherwise identical.

## Structure
- Package `tx_66b_pkg`:
  - IDLE_BLOCK.
  - SYNC_DATA=2'b01, SYNC_CTRL=2'b10.
  - State enum {ST_DISABLED, ST_INIT, ST_RUN}.
- One sub-module: `gearbox_seq_cnt` (SEQ_MAX parameter). Outputs the count, a pause flag and a next-is-pause flag.
- Framer FSM and datapath mux stay in the top.

## Test plan
- Reset release, link_en=0 for 50 cycles -> scr_enable=0 throughout, scr_data=IDLE_BLOCK, tx_sequence cycles 0..32 repeatedly.
- link_en=1, s_valid=1 -> exactly 16 enabled idles, then init_done=1 and first data word on scr_data with scr_sync=2'b01.
- Stream incrementing words 0,1,2,… across ≥3 pause slots:
  - Output sequence is contiguous with no gaps or duplicates.
  - scr_enable=0 only when tx_sequence=32.
  - s_ready=0 when tx_sequence=31.
- In RUN, s_valid low for 5 cycles -> 5 idle blocks with scr_enable=1, sync 2'b10. With TX_FRAMER_STATS_EN, idle_cnt increments by 5.
- s_ctrl=1 with s_data=64'h7800_0000_0000_00AA -> same value output with scr_sync=2'b10.
- link_en dropped mid-stream, then rst pulsed mid-stream:
  - After link_en drop: DISABLED the next cycle, s_ready=0, a fresh 16-idle INIT on re-enable.
  - On rst: all outputs go to reset values asynchronously.

Source files
------------

// File: rtl/tx_66b_pkg.sv
// Shared constants and types for the 64b/66b transmit framer.
package tx_66b_pkg;

    localparam logic [63:0] IDLE_BLOCK = 64'h1E00_0000_0000_0000;
    localparam logic [1:0]  SYNC_DATA  = 2'b01;
    localparam logic [1:0]  SYNC_CTRL  = 2'b10;

    typedef enum logic [1:0] {
        ST_DISABLED,
        ST_INIT,
        ST_RUN
    } tx_state_e;

    function automatic logic [1:0] sync_for(input logic ctrl);
        return ctrl ? SYNC_CTRL : SYNC_DATA;
    endfunction

endpackage

// File: rtl/tx_66b_framer_seq_cnt.sv
// Free-running gearbox sequence counter, 0..SEQ_MAX, with the last value as the pause slot.
module gearbox_seq_cnt #(
    parameter int SEQ_MAX = 32,
    parameter int CW      = $clog2(SEQ_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    output logic [CW-1:0] count,
    output logic          pause,
    output logic          next_pause
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (count == CW'(SEQ_MAX)) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign pause      = (count == CW'(SEQ_MAX));
    assign next_pause = (count == CW'(SEQ_MAX - 1));

endmodule

// File: rtl/tx_66b_framer.sv
// 64b/66b transmit sequencer: idle insertion, init idles, gearbox pause handling.
// Optional statistics counters are enabled by defining TX_FRAMER_STATS_EN.
module tx_66b_framer
    import tx_66b_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int SEQ_MAX    = 32,
    parameter int INIT_IDLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  link_en,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_ctrl,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] scr_data,
    output logic [1:0]            scr_sync,
    output logic                  scr_enable,
    output logic [5:0]            tx_sequence,
    output logic                  init_done
`ifdef TX_FRAMER_STATS_EN
    ,
    output logic [31:0]           data_cnt,
    output logic [31:0]           idle_cnt,
    output logic [31:0]           pause_cnt
`endif
);

    localparam int SEQ_W  = $clog2(SEQ_MAX + 1);
    localparam int INIT_W = $clog2(INIT_IDLES + 1);

    tx_state_e             state;
    tx_state_e             state_nxt;
    logic [SEQ_W-1:0]      seq;
    logic                  pause;
    logic                  next_pause;
    logic [INIT_W-1:0]     init_cnt;
    logic                  init_step;
    logic                  init_last;
    logic                  accept;
    logic [DATA_WIDTH-1:0] data_nxt;
    logic [1:0]            sync_nxt;
    logic                  en_nxt;

    gearbox_seq_cnt #(
        .SEQ_MAX (SEQ_MAX),
        .CW      (SEQ_W)
    ) u_seq (
        .clk        (clk),
        .rst        (rst),
        .count      (seq),
        .pause      (pause),
        .next_pause (next_pause)
    );

    assign tx_sequence = 6'(seq);
    assign accept      = s_valid && s_ready;
    // Only non-pause cycles count toward the init idle total.
    assign init_step   = (state == ST_INIT) && link_en && !next_pause;
    assign init_last   = init_step && (init_cnt == INIT_W'(INIT_IDLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_DISABLED;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!link_en) begin
            state_nxt = ST_DISABLED;
        end else begin
            case (state)
                ST_DISABLED: state_nxt = ST_INIT;
                ST_INIT:     if (init_last) state_nxt = ST_RUN;
                ST_RUN:      state_nxt = ST_RUN;
                default:     state_nxt = ST_DISABLED;
            endcase
        end
    end

    // Outputs: ready/done decode plus the next value of the scrambler-facing registers.
    always_comb begin
        s_ready   = (state == ST_RUN) && !next_pause;
        init_done = (state == ST_RUN);
        data_nxt  = scr_data;
        sync_nxt  = scr_sync;
        en_nxt    = 1'b0;
        if (!next_pause) begin
            if (accept) begin
                data_nxt = s_data;
                sync_nxt = sync_for(s_ctrl);
                en_nxt   = 1'b1;
            end else begin
                data_nxt = IDLE_BLOCK;
                sync_nxt = SYNC_CTRL;
                en_nxt   = link_en && (state != ST_DISABLED);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scr_data   <= IDLE_BLOCK;
            scr_sync   <= SYNC_CTRL;
            scr_enable <= 1'b0;
        end else begin
            scr_data   <= data_nxt;
            scr_sync   <= sync_nxt;
            scr_enable <= en_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_cnt <= '0;
        end else if ((state != ST_INIT) || !link_en) begin
            init_cnt <= '0;
        end else if (init_step) begin
            init_cnt <= init_cnt + INIT_W'(1);
        end
    end

`ifdef TX_FRAMER_STATS_EN
    logic entering_disabled;
    logic run_idle;

    assign entering_disabled = (state_nxt == ST_DISABLED) && (state != ST_DISABLED);
    assign run_idle          = (state == ST_RUN) && link_en && !next_pause && !accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_cnt  <= '0;
            idle_cnt  <= '0;
            pause_cnt <= '0;
        end else if (entering_disabled) begin
            data_cnt  <= '0;
            idle_cnt  <= '0;
            pause_cnt <= '0;
        end else begin
            if (accept)   data_cnt  <= data_cnt + 32'd1;
            if (run_idle) idle_cnt  <= idle_cnt + 32'd1;
            if (pause)    pause_cnt <= pause_cnt + 32'd1;
        end
    end
`else
    logic unused_pause;
    assign unused_pause = pause;
`endif

endmodule

// File: tb/tb_tx_66b_framer.sv
// Directed bench for tx_66b_framer: reset, init idles, streaming across pauses, table vectors, link drop, async reset.
module tb_tx_66b_framer;

    localparam logic [63:0] IDLE = 64'h1E00_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        link_en;
    logic [63:0] s_data;
    logic        s_ctrl;
    logic        s_valid;
    logic        s_ready;
    logic [63:0] scr_data;
    logic [1:0]  scr_sync;
    logic        scr_enable;
    logic [5:0]  tx_sequence;
    logic        init_done;
`ifdef TX_FRAMER_STATS_EN
    logic [31:0] data_cnt;
    logic [31:0] idle_cnt;
    logic [31:0] pause_cnt;
`endif

    tx_66b_framer dut (
        .clk         (clk),
        .rst         (rst),
        .link_en     (link_en),
        .s_data      (s_data),
        .s_ctrl      (s_ctrl),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .scr_data    (scr_data),
        .scr_sync    (scr_sync),
        .scr_enable  (scr_enable),
        .tx_sequence (tx_sequence),
        .init_done   (init_done)
`ifdef TX_FRAMER_STATS_EN
        ,
        .data_cnt    (data_cnt),
        .idle_cnt    (idle_cnt),
        .pause_cnt   (pause_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic        c;
        logic [63:0] d;
        logic        exp_en;
        logic [1:0]  exp_sync;
        logic [63:0] exp_data;
    } vec_t;

    vec_t        tbl [12];
    int          checks = 0;
    int          errors = 0;
    int          exp_seq;
    int          word;
    int          exp_out;
    int          n_idle;
    logic        seen_data;
    logic        acc;
    logic [63:0] prev_data;
    logic [31:0] snap;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_data"},  scr_data, IDLE);
        chk({tag, "_sync"},  64'(scr_sync), 64'(2'b10));
        chk({tag, "_en"},    64'(scr_enable), 64'(1'b0));
        chk({tag, "_ready"}, 64'(s_ready), 64'(1'b0));
        chk({tag, "_done"},  64'(init_done), 64'(1'b0));
        chk({tag, "_seq"},   64'(tx_sequence), 64'd0);
    endtask

    // Runs until the first data block appears; reports the number of enabled idles before it.
    task automatic wait_first_data(input string tag, input logic [63:0] exp_word);
        int cnt;
        logic found;
        cnt   = 0;
        found = 1'b0;
        for (int c = 0; c < 80 && !found; c++) begin
            step();
            if (scr_enable && scr_sync == 2'b01) begin
                found = 1'b1;
            end else if (scr_enable) begin
                cnt++;
            end
        end
        chk({tag, "_found"}, 64'(found), 64'(1'b1));
        chk({tag, "_idles"}, 64'(cnt), 64'd16);
        chk({tag, "_done"},  64'(init_done), 64'(1'b1));
        chk({tag, "_data"},  scr_data, exp_word);
    endtask

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 64'h0, 1'b1, 2'b10, IDLE};
        tbl[1]  = '{1'b0, 1'b0, 64'h0, 1'b1, 2'b10, IDLE};
        tbl[2]  = '{1'b0, 1'b1, 64'h0, 1'b1, 2'b10, IDLE};
        tbl[3]  = '{1'b0, 1'b0, 64'h0, 1'b1, 2'b10, IDLE};
        tbl[4]  = '{1'b0, 1'b0, 64'h0, 1'b1, 2'b10, IDLE};
        tbl[5]  = '{1'b1, 1'b1, 64'h7800_0000_0000_00AA, 1'b1, 2'b10, 64'h7800_0000_0000_00AA};
        tbl[6]  = '{1'b1, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b1, 2'b01, 64'h0123_4567_89AB_CDEF};
        tbl[7]  = '{1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF};
        tbl[8]  = '{1'b0, 1'b0, 64'hDEAD_BEEF_0000_0000, 1'b1, 2'b10, IDLE};
        tbl[9]  = '{1'b1, 1'b1, 64'h1E00_0000_0000_0001, 1'b1, 2'b10, 64'h1E00_0000_0000_0001};
        tbl[10] = '{1'b1, 1'b0, 64'h0, 1'b1, 2'b01, 64'h0};
        tbl[11] = '{1'b1, 1'b0, 64'h8000_0000_0000_0001, 1'b1, 2'b01, 64'h8000_0000_0000_0001};

        rst     = 1'b1;
        link_en = 1'b0;
        s_valid = 1'b0;
        s_ctrl  = 1'b0;
        s_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_values("rst");
        rst     = 1'b0;
        exp_seq = 0;

        // Link disabled: no scrambler advance, counter free-runs.
        for (int c = 0; c < 50; c++) begin
            step();
            exp_seq = (exp_seq + 1) % 33;
            chk("dis_seq",   64'(tx_sequence), 64'(exp_seq));
            chk("dis_en",    64'(scr_enable), 64'(1'b0));
            chk("dis_data",  scr_data, IDLE);
            chk("dis_ready", 64'(s_ready), 64'(1'b0));
        end

        // Enable and stream incrementing words across several pause slots.
        link_en   = 1'b1;
        s_valid   = 1'b1;
        word      = 0;
        s_data    = 64'd0;
        exp_out   = 0;
        n_idle    = 0;
        seen_data = 1'b0;
        for (int c = 0; c < 400 && exp_out < 110; c++) begin
            acc       = s_valid && s_ready;
            prev_data = scr_data;
            step();
            exp_seq = (exp_seq + 1) % 33;
            if (acc) begin
                word++;
                s_data = 64'(word);
            end
            chk("run_seq", 64'(tx_sequence), 64'(exp_seq));
            if (tx_sequence == 6'd32) begin
                chk("pause_en",   64'(scr_enable), 64'(1'b0));
                chk("pause_hold", scr_data, prev_data);
            end else if (scr_enable && scr_sync == 2'b01) begin
                if (!seen_data) begin
                    chk("init_idles", 64'(n_idle), 64'd16);
                    chk("init_done",  64'(init_done), 64'(1'b1));
                    seen_data = 1'b1;
                end
                chk("stream_data", scr_data, 64'(exp_out));
                exp_out++;
            end else if (scr_enable) begin
                if (seen_data) chk("stream_gap", 64'(scr_sync), 64'(2'b01));
                else n_idle++;
            end
            if (init_done) begin
                chk("run_ready", 64'(s_ready), 64'(tx_sequence != 6'd31));
                chk("run_en",    64'(scr_enable), 64'(tx_sequence != 6'd32));
            end
        end
        chk("stream_len", 64'(exp_out), 64'd110);
        chk("no_loss",    64'(word), 64'(exp_out));
`ifdef TX_FRAMER_STATS_EN
        chk("stat_data", 64'(data_cnt), 64'(word));
`endif

        // Drain to the start of a sequence period so the table avoids the pause slot.
        s_valid = 1'b0;
        for (int c = 0; c < 40 && tx_sequence != 6'd0; c++) begin
            step();
        end
        chk("drain_seq", 64'(tx_sequence), 64'd0);

`ifdef TX_FRAMER_STATS_EN
        snap = idle_cnt;
`else
        snap = '0;
`endif
        for (int i = 0; i < 12; i++) begin
            s_valid = tbl[i].v;
            s_ctrl  = tbl[i].c;
            s_data  = tbl[i].d;
            chk($sformatf("tbl_ready[%0d]", i), 64'(s_ready), 64'(1'b1));
            step();
            chk($sformatf("tbl_en[%0d]", i),   64'(scr_enable), 64'(tbl[i].exp_en));
            chk($sformatf("tbl_sync[%0d]", i), 64'(scr_sync), 64'(tbl[i].exp_sync));
            chk($sformatf("tbl_data[%0d]", i), scr_data, tbl[i].exp_data);
            chk($sformatf("tbl_seq[%0d]", i),  64'(tx_sequence), 64'(i + 1));
`ifdef TX_FRAMER_STATS_EN
            if (i == 4) chk("stat_idle5", 64'(idle_cnt - snap), 64'd5);
`endif
        end

        // Drop link_en while a word is being accepted.
        s_valid = 1'b1;
        s_ctrl  = 1'b0;
        s_data  = 64'hA5A5_0000_0000_5A5A;
        link_en = 1'b0;
        chk("drop_ready_pre", 64'(s_ready), 64'(1'b1));
        step();
        chk("drop_data",  scr_data, 64'hA5A5_0000_0000_5A5A);
        chk("drop_sync",  64'(scr_sync), 64'(2'b01));
        chk("drop_en",    64'(scr_enable), 64'(1'b1));
        chk("drop_ready", 64'(s_ready), 64'(1'b0));
        chk("drop_done",  64'(init_done), 64'(1'b0));
        step();
        chk("dropped_en",   64'(scr_enable), 64'(1'b0));
        chk("dropped_data", scr_data, IDLE);
`ifdef TX_FRAMER_STATS_EN
        chk("stat_clear", 64'(data_cnt), 64'd0);
`endif

        // Re-enable: a fresh init sequence must precede data.
        s_data  = 64'hC3C3_1111_2222_3C3C;
        link_en = 1'b1;
        wait_first_data("reinit", 64'hC3C3_1111_2222_3C3C);
        repeat (3) step();

        // Asynchronous reset between clock edges.
        #3;
        rst = 1'b1;
        #1;
        chk_reset_values("arst");
        link_en = 1'b0;
        s_valid = 1'b0;
        step();
        chk_reset_values("arst_hold");
        rst = 1'b0;
        step();
        chk("post_rst_seq", 64'(tx_sequence), 64'd1);
        chk("post_rst_en",  64'(scr_enable), 64'(1'b0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
